sensor_frame_sequencer: RTL
===========================

// Module: sensor_frame_sequencer
// PURPOSE
//  Parametrised successor to the fixed pixel-sensor state machine. Sequences erase -> expose -> convert -> readout for an
//  N-row pixel array with runtime exposure length, single-shot/continuous mode and ready/valid row readout backpressure.
//  Sits between the top-level controller and the pixel array and ADC readout path.
// PARAMETERS
//  PIXEL_ARRAY_HEIGHT  2    rows in array; width of SENSOR_ROW_SELECT
//  PIXEL_BITS          8    ADC resolution; width of digital ramp
//  ERASE_CYCLES        5    cycles PIXEL_ERASE is held high, >=1
//  EXPOSE_BITS         16   width of exposure-length config
// PORTS
//  CLK                 in   1                   main clock, all logic on rising edge
//  RESET_N             in   1                   async active-low reset
//  START               in   1                   begin frame; sampled only in IDLE
//  ABORT               in   1                   sync abort to IDLE, priority over all else
//  CONTINUOUS          in   1                   1: restart after frame; sampled at START and at frame end
//  EXPOSE_CYCLES       in   EXPOSE_BITS         exposure length, latched at START
//  ROW_READY           in   1                   downstream accepts current row
//  PIXEL_ERASE         out  1                   erase strobe to pixels
//  PIXEL_EXPOSE        out  1                   expose enable to pixels
//  PIXEL_CONVERT       out  1                   ramp conversion active
//  PIXEL_DIGITAL_RAMP  out  PIXEL_BITS          ADC ramp code
//  SENSOR_ROW_SELECT   out  PIXEL_ARRAY_HEIGHT  one-hot row select, 0 when not READOUT
//  ROW_VALID           out  1                   row select is valid for readout
//  ROW_INDEX           out  $clog2(HEIGHT)      binary index of selected row
//  FRAME_DONE          out  1                   1-cycle pulse on last-row handshake
//  BUSY                out  1                   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; latched exposure=0; ramp=0.
//  - Registered Moore outputs: every output reflects the current state, with no combinational path from inputs.
//  - IDLE: START=1 -> ERASE next cycle; latch EXPOSE_CYCLES (0 treated as 1) and CONTINUOUS.
//  - ERASE: PIXEL_ERASE=1 for exactly ERASE_CYCLES cycles -> EXPOSE.
//  - EXPOSE: PIXEL_EXPOSE=1 for exactly the latched count of cycles -> CONVERT.
//  - CONVERT: PIXEL_CONVERT=1. Ramp steps 0,1,..,2^PIXEL_BITS-1, one step per cycle (2^PIXEL_BITS cycles total).
//    The ramp does not wrap inside CONVERT; after the max code -> READOUT, and the ramp returns to 0.
//  - READOUT: row r=0 first. ROW_VALID=1, SENSOR_ROW_SELECT=1<<r, ROW_INDEX=r.
//    Row holds stable while ROW_VALID & !ROW_READY; r advances on ROW_VALID & ROW_READY.
//  - Last-row handshake: FRAME_DONE=1 for one cycle.
//    Then if latched CONTINUOUS -> ERASE (EXPOSE_CYCLES re-latched), else -> IDLE.
//  - START outside IDLE is ignored. A CONTINUOUS change takes effect only at the next frame boundary.
//  - ABORT=1 in any state -> IDLE next edge. Outputs go to reset values and FRAME_DONE is not asserted.
//    ABORT wins over a simultaneous START or last-row handshake.
//  - RESET_N low mid-frame: immediate async return to reset values. The frame is lost and not resumed.
//  - Counters are sized to max(ERASE_CYCLES, 2^EXPOSE_BITS-1, 2^PIXEL_BITS-1) and never overflow.
// CONFIGURATION
//  SENSOR_FRAME_COUNT_EN defined:
//    - Adds output FRAME_COUNT[15:0]: 0 at reset, +1 on each FRAME_DONE, wraps 16'hFFFF->0.
//    - ABORT does not change it.
//  Not defined: port absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  - Package PixelSensorConfig gains:
//    - typedef enum logic [2:0] {SEQ_IDLE, SEQ_ERASE, SEQ_EXPOSE, SEQ_CONVERT, SEQ_READOUT} seq_state_t
//    - constants ERASE_CYCLES and EXPOSE_BITS, defaulting the module parameters
//  - One sub-module: sensor_ramp_counter. PIXEL_BITS up-counter with enable, clear and terminal-count flag.
//    Used for the CONVERT ramp.
//  - Remaining counters are inline.
// TESTING (HEIGHT=2, PIXEL_BITS=4, ERASE_CYCLES=5, MAIN_CLK_PERIOD clock)
//  1 Single shot:
//    - Stimulus: START=1 for 1 cycle, EXPOSE_CYCLES=10, ROW_READY=1.
//    - Response: ERASE 5 cyc, EXPOSE 10, ramp 0..15 over 16, rows 01 then 10, one cycle each.
//      FRAME_DONE one cycle, then IDLE with BUSY=0.
//  2 Backpressure:
//    - Stimulus: ROW_READY=0 for 7 cycles in READOUT.
//    - Response: row 0 held with ROW_INDEX=0 and ROW_VALID=1 throughout; advances 1 cycle after READY=1.
//  3 Continuous:
//    - Stimulus: CONTINUOUS=1; on frame 2 change EXPOSE_CYCLES to 3.
//    - Response: 3 frames back-to-back, ERASE immediately after FRAME_DONE, frame 2 EXPOSE=3 cyc.
//    - Then CONTINUOUS=0: stops after the current frame.
//  4 Abort/reset:
//    - Stimulus: ABORT mid-CONVERT at ramp=7.
//    - Response: next cycle all outputs 0, no FRAME_DONE.
//    - Stimulus: RESET_N low mid-EXPOSE. Response: outputs 0 with no clock edge.
//  5 Edge cases:
//    - EXPOSE_CYCLES=0 -> EXPOSE lasts 1 cycle.
//    - START during READOUT -> ignored.
//    - FRAME_COUNT (macro on) reads 2 after 2 frames and 0 after reset.

Source files
------------

// File: rtl/sensor_frame_sequencer_pkg.sv
// Shared types and default constants for the pixel-sensor frame sequencer.
// Imported by sensor_frame_sequencer and its ramp counter.
package PixelSensorConfig;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_ERASE,
      SEQ_EXPOSE,
      SEQ_CONVERT,
      SEQ_READOUT
   } seq_state_t;

   localparam int ERASE_CYCLES = 5;
   localparam int EXPOSE_BITS  = 16;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sensor_frame_sequencer_ramp_counter.sv
// PIXEL_BITS-wide up-counter generating the ADC conversion ramp code.
// Clear has priority over enable; o_tc flags the maximum code.
module sensor_ramp_counter
   import PixelSensorConfig::*;
#(
   parameter int PIXEL_BITS = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_clr,
   output logic [PIXEL_BITS-1:0] o_count,
   output logic                  o_tc
);

   logic [PIXEL_BITS-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + PIXEL_BITS'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == '1);

endmodule

// File: rtl/sensor_frame_sequencer.sv
// Erase -> expose -> convert -> readout sequencer for an N-row pixel array.
// Optional FRAME_COUNT output is enabled by defining SENSOR_FRAME_COUNT_EN.
module sensor_frame_sequencer
   import PixelSensorConfig::*;
#(
   parameter int  PIXEL_ARRAY_HEIGHT = 2,
   parameter int  PIXEL_BITS         = 8,
   parameter int  ERASE_CYCLES       = PixelSensorConfig::ERASE_CYCLES,
   parameter int  EXPOSE_BITS        = PixelSensorConfig::EXPOSE_BITS,
   localparam int ROW_W              = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          START,
   input  logic                          ABORT,
   input  logic                          CONTINUOUS,
   input  logic [EXPOSE_BITS-1:0]        EXPOSE_CYCLES,
   input  logic                          ROW_READY,
   output logic                          PIXEL_ERASE,
   output logic                          PIXEL_EXPOSE,
   output logic                          PIXEL_CONVERT,
   output logic [PIXEL_BITS-1:0]         PIXEL_DIGITAL_RAMP,
   output logic [PIXEL_ARRAY_HEIGHT-1:0] SENSOR_ROW_SELECT,
   output logic                          ROW_VALID,
   output logic [ROW_W-1:0]              ROW_INDEX,
   output logic                          FRAME_DONE,
`ifdef SENSOR_FRAME_COUNT_EN
   output logic [15:0]                   FRAME_COUNT,
`endif
   output logic                          BUSY
);

   localparam int CNT_MAX = max3(ERASE_CYCLES, (2**EXPOSE_BITS) - 1, (2**PIXEL_BITS) - 1);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   seq_state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0]       r_expose;
   logic [ROW_W-1:0]       r_row, w_row_nxt;
   logic                   r_cont;
   logic                   r_frame_done, w_done_nxt;
   logic                   w_latch;
   logic                   w_ramp_en, w_ramp_clr, w_ramp_tc;
   logic [PIXEL_BITS-1:0]  w_ramp;

   sensor_ramp_counter #(.PIXEL_BITS(PIXEL_BITS)) u_ramp (
      .i_clk   (CLK),
      .i_rst_n (RESET_N),
      .i_en    (w_ramp_en),
      .i_clr   (w_ramp_clr),
      .o_count (w_ramp),
      .o_tc    (w_ramp_tc)
   );

   // The ramp is held at 0 everywhere except CONVERT and returns to 0 on the max code.
   assign w_ramp_en  = (r_state == SEQ_CONVERT);
   assign w_ramp_clr = (r_state != SEQ_CONVERT) | ABORT | w_ramp_tc;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_row_nxt   = r_row;
      w_done_nxt  = 1'b0;
      w_latch     = 1'b0;
      if (ABORT) begin
         w_state_nxt = SEQ_IDLE;
         w_cnt_nxt   = '0;
         w_row_nxt   = '0;
      end else begin
         case (r_state)
            SEQ_IDLE: begin
               if (START) begin
                  w_state_nxt = SEQ_ERASE;
                  w_cnt_nxt   = '0;
                  w_latch     = 1'b1;
               end
            end
            SEQ_ERASE: begin
               if (r_cnt == CNT_W'(ERASE_CYCLES - 1)) begin
                  w_state_nxt = SEQ_EXPOSE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            SEQ_EXPOSE: begin
               if (r_cnt == r_expose - CNT_W'(1)) begin
                  w_state_nxt = SEQ_CONVERT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            SEQ_CONVERT: begin
               if (w_ramp_tc) begin
                  w_state_nxt = SEQ_READOUT;
               end
            end
            SEQ_READOUT: begin
               if (ROW_READY) begin
                  if (r_row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1)) begin
                     w_done_nxt = 1'b1;
                     w_row_nxt  = '0;
                     w_cnt_nxt  = '0;
                     if (r_cont) begin
                        w_state_nxt = SEQ_ERASE;
                        w_latch     = 1'b1;
                     end else begin
                        w_state_nxt = SEQ_IDLE;
                     end
                  end else begin
                     w_row_nxt = r_row + ROW_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = SEQ_IDLE;
               w_cnt_nxt   = '0;
               w_row_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= SEQ_IDLE;
         r_cnt        <= '0;
         r_row        <= '0;
         r_frame_done <= 1'b0;
         r_expose     <= '0;
         r_cont       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_row        <= w_row_nxt;
         r_frame_done <= w_done_nxt;
         // Exposure and mode are captured at START and again at each continuous restart.
         if (w_latch) begin
            r_expose <= (EXPOSE_CYCLES == '0) ? CNT_W'(1) : CNT_W'(EXPOSE_CYCLES);
            r_cont   <= CONTINUOUS;
         end
      end
   end

`ifdef SENSOR_FRAME_COUNT_EN
   logic [15:0] r_frame_count;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_frame_count <= '0;
      end else if (r_frame_done) begin
         r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign FRAME_COUNT = r_frame_count;
`endif

   assign PIXEL_ERASE        = (r_state == SEQ_ERASE);
   assign PIXEL_EXPOSE       = (r_state == SEQ_EXPOSE);
   assign PIXEL_CONVERT      = (r_state == SEQ_CONVERT);
   assign PIXEL_DIGITAL_RAMP = w_ramp;
   assign ROW_VALID          = (r_state == SEQ_READOUT);
   assign SENSOR_ROW_SELECT  = ROW_VALID ? (PIXEL_ARRAY_HEIGHT'(1) << r_row) : '0;
   assign ROW_INDEX          = ROW_VALID ? r_row : '0;
   assign FRAME_DONE         = r_frame_done;
   assign BUSY               = (r_state != SEQ_IDLE);

endmodule
